// File: rtl/alu_ctrl_pkg.sv
// Shared types and defaults for the ALU request arbiter.
// Holds widths, requester count and FSM state encoding.
package alu_ctrl_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int N_REQ      = 2;
  localparam int OPS_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index of the granted requester from a one-hot grant.
  function automatic logic grant_idx(input logic [1:0] g);
    return g[1];
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response channels of the two ALU requesters.
// master = requester side, slave = arbiter side.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [SEL_W-1:0]  req0_sel;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [SEL_W-1:0]  req1_sel;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_cout;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_cout,
    input  rsp1_valid, rsp1_result, rsp1_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_cout,
    output rsp1_valid, rsp1_result, rsp1_cout
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester
// that did not own the ALU last time wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  input  logic       enable,
  output logic [1:0] grant
);

  logic both;
  logic only0;
  logic only1;

  assign both  = enable & valid[0] & valid[1];
  assign only0 = enable & valid[0] & ~valid[1];
  assign only1 = enable & ~valid[0] & valid[1];

  // One-hot grant from mutually exclusive request cases.
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      both:    grant = last_owner ? 2'b01 : 2'b10;
      only0:   grant = 2'b01;
      only1:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external ALU between two requesters:
// accept -> one EXEC cycle -> hold response until taken.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  alu_req_arbiter_if.slave  bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              busy,
  output logic [OPS_W-1:0]  ops_done
);

  state_t             state;
  logic               owner;
  logic               last_owner;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [N_REQ-1:0]   rsp_cout_q;
  logic [DATA_W-1:0]  rsp_result_q [N_REQ];
  logic [OPS_W-1:0]   ops_q;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [1:0]         grant;
  logic               arb_en;
  logic               accept;
  logic               win;
  logic               rsp_hs;
  logic [DATA_W-1:0]  win_a;
  logic [DATA_W-1:0]  win_b;
  logic [SEL_W-1:0]   win_sel;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // Grants only in IDLE, enabled and out of reset.
  assign arb_en = ena & rst_n & (state == IDLE);

  rr_arbiter2 u_rr (
    .valid      (req_valid),
    .last_owner (last_owner),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign accept  = |grant;
  assign win     = grant_idx(grant);
  assign win_a   = win ? bus.req1_a   : bus.req0_a;
  assign win_b   = win ? bus.req1_b   : bus.req0_b;
  assign win_sel = win ? bus.req1_sel : bus.req0_sel;
  assign rsp_hs  = rsp_ready[owner];

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = rsp_result_q[0];
  assign bus.rsp1_result = rsp_result_q[1];
  assign bus.rsp0_cout   = rsp_cout_q[0];
  assign bus.rsp1_cout   = rsp_cout_q[1];

  assign busy     = (state != IDLE);
  assign ops_done = ops_q;

  // Control FSM with operand, response and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      rsp_valid_q <= '0;
      rsp_cout_q  <= '0;
      ops_q       <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_result_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= win_a;
            alu_b   <= win_b;
            alu_sel <= win_sel;
            owner   <= win;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q[owner] <= alu_result;
          rsp_cout_q[owner]   <= alu_cout;
          rsp_valid_q[owner]  <= 1'b1;
          state               <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q[owner] <= 1'b0;
            last_owner         <= owner;
            ops_q              <= ops_q + 8'd1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural
// ALU (sel 000 = ADD) on the shared operand bus.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic       busy;
  logic [7:0] ops_done;
  logic [8:0] alu_sum;

  int n_checks;
  int n_fail;

  alu_req_arbiter_if #(.DATA_W(8), .SEL_W(3)) bus ();

  alu_req_arbiter #(.DATA_W(8), .SEL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_sum = 9'd0;
    case (alu_sel)
      3'b000:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_sum = {1'b0, alu_a & alu_b};
    endcase
  end
  assign alu_result = alu_sum[7:0];
  assign alu_cout   = alu_sum[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_sel = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_sel = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    ena = 1;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    ena = 1;
    clear_inputs();
    bus.req0_valid = 1;
    bus.req0_a = 8'h11;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready0: got %b want 0", bus.req0_ready);
    end
    n_checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_cout, bus.rsp1_cout} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_rsp_flags: got %b want 0000",
               {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_cout, bus.rsp1_cout});
    end
    n_checks++;
    if ({bus.rsp0_result, bus.rsp1_result} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rsp_result: got %h want 0000",
               {bus.rsp0_result, bus.rsp1_result});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_sel} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_alu_bus: got %h want 0", {alu_a, alu_b, alu_sel});
    end
    n_checks++;
    if (busy !== 1'b0 || ops_done !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_busy_ops: got %b/%0d want 0/0", busy, ops_done);
    end
    bus.req0_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic_add();
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 8'h05; bus.req0_b = 8'h03; bus.req0_sel = 3'b000;
    bus.rsp0_ready = 1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_grant_c0: got %b%b want 01", bus.req1_ready, bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || bus.rsp0_valid !== 1'b0 || alu_a !== 8'h05 || alu_b !== 8'h03) begin
      n_fail++;
      $display("FAIL basic_exec_c1: got busy=%b rsp=%b a=%h b=%h want 1 0 05 03",
               busy, bus.rsp0_valid, alu_a, alu_b);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8'h08 ||
        bus.rsp0_cout !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_resp_c2: got v=%b r=%h c=%b v1=%b want 1 08 0 0",
               bus.rsp0_valid, bus.rsp0_result, bus.rsp0_cout, bus.rsp1_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.rsp0_valid !== 1'b0 || ops_done !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_c3: got v=%b ops=%0d busy=%b want 0 1 0",
               bus.rsp0_valid, ops_done, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 8'h0A; bus.req0_b = 8'h14; bus.req0_sel = 3'b000;
    bus.req1_valid = 1; bus.req1_a = 8'h40; bus.req1_b = 8'h41; bus.req1_sel = 3'b000;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (bus.req0_ready !== (c % 6 == 0) || bus.req1_ready !== (c % 6 == 3)) begin
        n_fail++;
        $display("FAIL rr_grant cycle %0d: got %b%b want %b%b", c,
                 bus.req1_ready, bus.req0_ready, (c % 6 == 3), (c % 6 == 0));
      end
      n_checks++;
      if (bus.rsp0_valid !== (c % 6 == 2) || bus.rsp1_valid !== (c % 6 == 5)) begin
        n_fail++;
        $display("FAIL rr_rsp_valid cycle %0d: got %b%b want %b%b", c,
                 bus.rsp1_valid, bus.rsp0_valid, (c % 6 == 5), (c % 6 == 2));
      end
      if (c % 6 == 2) begin
        n_checks++;
        if (bus.rsp0_result !== 8'h1E) begin
          n_fail++;
          $display("FAIL rr_result0 cycle %0d: got %h want 1e", c, bus.rsp0_result);
        end
      end
      if (c % 6 == 5) begin
        n_checks++;
        if (bus.rsp1_result !== 8'h81) begin
          n_fail++;
          $display("FAIL rr_result1 cycle %0d: got %h want 81", c, bus.rsp1_result);
        end
      end
    end
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    n_checks++;
    if (ops_done !== 8'd4) begin
      n_fail++;
      $display("FAIL rr_ops_done: got %0d want 4", ops_done);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 8'hFF; bus.req0_b = 8'h01; bus.req0_sel = 3'b000;
    bus.req1_valid = 1; bus.req1_a = 8'h01; bus.req1_b = 8'h01; bus.req1_sel = 3'b000;
    bus.rsp0_ready = 0; bus.rsp1_ready = 1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first_tie: got %b%b want 01", bus.req1_ready, bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 0;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8'h00 || bus.rsp0_cout !== 1'b1 ||
          bus.req1_ready !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got v=%b r=%h c=%b rdy1=%b v1=%b want 1 00 1 0 0",
                 c, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_cout,
                 bus.req1_ready, bus.rsp1_valid);
      end
    end
    @(negedge clk);
    bus.rsp0_ready = 1;
    #1;
    n_checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b rdy1=%b want 1 0", bus.rsp0_valid, bus.req1_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1 || bus.rsp0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_req1_grant: got rdy1=%b v0=%b want 1 0", bus.req1_ready, bus.rsp0_valid);
    end
    @(negedge clk);
    bus.req1_valid = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 8'h02 || bus.rsp1_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_req1_resp: got v=%b r=%h c=%b want 1 02 0",
               bus.rsp1_valid, bus.rsp1_result, bus.rsp1_cout);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (ops_done !== 8'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ops_done: got %0d busy=%b want 2 0", ops_done, busy);
    end
  endtask

  task automatic test_enable();
    do_reset();
    ena = 0;
    bus.req1_valid = 1; bus.req1_a = 8'h03; bus.req1_b = 8'h04; bus.req1_sel = 3'b000;
    bus.rsp1_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (bus.req1_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ena_blocked cycle %0d: got rdy1=%b busy=%b want 0 0",
                 c, bus.req1_ready, busy);
      end
    end
    @(negedge clk);
    ena = 1;
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ena_grant: got %b want 1", bus.req1_ready);
    end
    @(negedge clk);
    ena = 0;
    bus.req1_valid = 0;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ena_no_abort_exec: got busy=%b want 1", busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 8'h07) begin
        n_fail++;
        $display("FAIL ena_no_abort_resp %0d: got v=%b r=%h want 1 07",
                 c, bus.rsp1_valid, bus.rsp1_result);
      end
    end
    bus.rsp1_ready = 1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.rsp1_valid !== 1'b0 || ops_done !== 8'd1) begin
      n_fail++;
      $display("FAIL ena_done: got v=%b ops=%0d want 0 1", bus.rsp1_valid, ops_done);
    end
    ena = 1;
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 8'h09; bus.req0_b = 8'h09; bus.req0_sel = 3'b000;
    bus.rsp0_ready = 1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rexec_grant: got %b want 1", bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 0;
    #1;
    n_checks++;
    if (alu_a !== 8'h09 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rexec_in_exec: got a=%h busy=%b want 09 1", alu_a, busy);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (alu_a !== 8'h00 || alu_b !== 8'h00 || busy !== 1'b0 ||
        bus.rsp0_valid !== 1'b0 || ops_done !== 8'd0) begin
      n_fail++;
      $display("FAIL rexec_async: got a=%h b=%h busy=%b v=%b ops=%0d want 0 0 0 0 0",
               alu_a, alu_b, busy, bus.rsp0_valid, ops_done);
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rexec_no_rsp %0d: got v0=%b v1=%b busy=%b want 0 0 0",
                 c, bus.rsp0_valid, bus.rsp1_valid, busy);
      end
    end
  endtask

  task automatic test_ops_wrap();
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 8'h01; bus.req0_b = 8'h01; bus.req0_sel = 3'b000;
    bus.rsp0_ready = 1;
    repeat (765) @(negedge clk);
    #1;
    n_checks++;
    if (ops_done !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_255: got %0d want 255", ops_done);
    end
    repeat (3) @(negedge clk);
    bus.req0_valid = 0;
    #1;
    n_checks++;
    if (ops_done !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_0: got %0d want 0", ops_done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 0;
    ena      = 1;
    clear_inputs();
    test_reset();
    test_basic_add();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_reset_in_exec();
    test_ops_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand/result width.
REQ-002 SHALL have parameter SEL_W, default 3: ALU operation-select width.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1: global enable; low blocks new grants.
REQ-006 SHALL have ports reqN_valid (input, 1), request pending from requester N, N in {0,1}.
REQ-007 SHALL have ports reqN_ready (output, 1), request accepted this cycle.
REQ-008 SHALL have ports reqN_a (input, DATA_W), reqN_b (input, DATA_W) and reqN_sel (input, SEL_W): operands and operation.
REQ-009 SHALL have ports alu_a (output, DATA_W), alu_b (output, DATA_W) and alu_sel (output, SEL_W): registered drive to the shared alu_8bit.
REQ-010 SHALL have ports alu_result (input, DATA_W) and alu_cout (input, 1): combinational ALU return.
REQ-011 SHALL have ports rspN_valid (output, 1), rspN_ready (input, 1), rspN_result (output, DATA_W) and rspN_cout (output, 1): response channel per requester.
REQ-012 SHALL have port busy, output, 1: state != IDLE.
REQ-013 SHALL have port ops_done, output, 8: count of completed responses.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 In IDLE with ena=1 and at least one reqN_valid, SHALL assert reqN_ready for exactly one winner, combinationally, in that cycle.
REQ-016 Arbitration SHALL be round-robin: on both valid, grant requester != last_owner; on one valid, grant it.
REQ-017 On the valid&ready edge, SHALL latch a/b/sel into alu_a/alu_b/alu_sel, record owner, and go to EXEC.
REQ-018 EXEC SHALL last exactly one cycle; at its closing edge SHALL capture alu_result/alu_cout into the owner's rsp registers and go to RESP.
REQ-019 In RESP, SHALL hold rsp<owner>_valid=1 with stable result/cout until rsp<owner>_ready=1; the non-owner's rsp_valid SHALL stay 0.
REQ-020 On the RESP handshake edge, SHALL set last_owner=owner, increment ops_done (mod 256, 255->0), and go to IDLE.
REQ-021 Minimum accept-to-next-accept interval SHALL be 3 cycles (IDLE, EXEC, RESP with ready already high).
REQ-022 reqN_ready SHALL be 0 outside IDLE and whenever ena=0; ena=0 SHALL NOT abort EXEC or RESP.
REQ-023 Requester dropping valid before ready SHALL simply not be granted; no state change.
REQ-024 alu_a/alu_b/alu_sel SHALL hold their last value outside the accept edge.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, all reqN_ready=0, rspN_valid=0, rspN_result=0, rspN_cout=0, alu_a=0, alu_b=0, alu_sel=0, busy=0, ops_done=0, last_owner=1 (requester 0 wins the first tie).
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued.

Structure
REQ-027 Package alu_ctrl_pkg SHALL hold DATA_W/SEL_W defaults, the FSM state enum and the requester count (2).
REQ-028 Round-robin grant logic SHALL be the sub-module rr_arbiter2 (valid[1:0], last_owner, enable -> one-hot grant).
REQ-029 The top level SHALL instantiate alu_8bit externally; the arbiter SHALL contain no arithmetic.

Verification (bench connects alu_8bit, sel=3'b000 is ADD)
REQ-030 Reset, then req0 a=8'h05 b=8'h03 sel=000, rsp0_ready=1 -> req0_ready in cycle 0, rsp0_valid in cycle 2, rsp0_result=8'h08, cout=0, ops_done=1.
REQ-031 Both requesters valid after reset -> order req0, req1, req0, req1; no back-to-back grant to the same requester.
REQ-032 req0 a=8'hFF b=8'h01 ADD, rsp0_ready held low 5 cycles -> rsp0_valid held, result=8'h00, cout=1 stable; req1 not granted until release.
REQ-033 ena=0 with req1_valid=1 -> req1_ready stays 0; ena=1 -> grant next cycle.
REQ-034 rst_n pulsed low in EXEC -> all outputs 0 immediately; no rsp_valid afterwards.
REQ-035 256 completed operations -> ops_done wraps to 0.
